// File: rtl/arbitro_clasificacion_if.sv
// arbitro_clasificacion_if: Main FIFO read side and VC0/VC1 push side of the classifier
interface arbitro_clasificacion_if #(
  parameter int DATA_WIDTH = 6,
  parameter int CNT_W      = 5
);
  logic [DATA_WIDTH-1:0] Main_in;
  logic                  Main_empty;
  logic                  VC0_pause;
  logic                  VC1_pause;
  logic                  Main_pop;
  logic                  VC0_push;
  logic                  VC1_push;
  logic [DATA_WIDTH-1:0] VC0_out;
  logic [DATA_WIDTH-1:0] VC1_out;
  logic [CNT_W-1:0]      VC0_count;
  logic [CNT_W-1:0]      VC1_count;
  logic                  idle;
  modport master (
    input  Main_in, Main_empty, VC0_pause, VC1_pause,
    output Main_pop, VC0_push, VC1_push, VC0_out, VC1_out, VC0_count, VC1_count, idle
  );
  modport slave (
    output Main_in, Main_empty, VC0_pause, VC1_pause,
    input  Main_pop, VC0_push, VC1_push, VC0_out, VC1_out, VC0_count, VC1_count, idle
  );
endinterface

// File: rtl/arbitro_clasificacion.sv
// arbitro_clasificacion: drains the Main FIFO and pushes each word to VC0 or VC1 by its class bit,
// parking it in a one-entry hold register while the target VC is paused.
module arbitro_clasificacion #(
  parameter int DATA_WIDTH = 6,
  parameter int CLASS_BIT  = 5,
  parameter int CNT_W      = 5
) (
  input logic                    clk,
  input logic                    reset_L,
  arbitro_clasificacion_if.master arb_io
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FLOW = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q, word;
  logic                  hold_v_q;
  logic                  pause_in, pause_h, pop, park, do_push, tgt;
  logic                  vc0_push_q, vc1_push_q;
  logic [DATA_WIDTH-1:0] vc0_out_q, vc1_out_q;
  logic [CNT_W-1:0]      vc0_cnt_q, vc1_cnt_q;
  always_comb begin
    pause_in = arb_io.Main_in[CLASS_BIT] ? arb_io.VC1_pause : arb_io.VC0_pause;
    pause_h  = hold_q[CLASS_BIT] ? arb_io.VC1_pause : arb_io.VC0_pause;
    park     = (state_q == FLOW) & pause_in;
    pop      = ~arb_io.Main_empty & (state_q != HOLD) & ~park;
    word     = (state_q == HOLD) ? hold_q : arb_io.Main_in;
    do_push  = ((state_q == FLOW) & ~pause_in) | ((state_q == HOLD) & ~pause_h);
    tgt      = word[CLASS_BIT];
    state_d  = (state_q == HOLD) ? (pause_h ? HOLD : IDLE) :
               park ? HOLD : pop ? FLOW : IDLE;
  end
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      hold_v_q   <= 1'b0;
      vc0_push_q <= 1'b0;
      vc1_push_q <= 1'b0;
      vc0_out_q  <= '0;
      vc1_out_q  <= '0;
      vc0_cnt_q  <= '0;
      vc1_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      vc0_push_q <= do_push & ~tgt;
      vc1_push_q <= do_push & tgt;
      if (do_push & ~tgt) begin
        vc0_out_q <= word;
        vc0_cnt_q <= vc0_cnt_q + 1'b1;
      end
      if (do_push & tgt) begin
        vc1_out_q <= word;
        vc1_cnt_q <= vc1_cnt_q + 1'b1;
      end
      if (park) begin
        hold_q   <= arb_io.Main_in;
        hold_v_q <= 1'b1;
      end else if ((state_q == HOLD) & ~pause_h) begin
        hold_v_q <= 1'b0;
      end
    end
  end
  assign arb_io.Main_pop  = pop;
  assign arb_io.VC0_push  = vc0_push_q;
  assign arb_io.VC1_push  = vc1_push_q;
  assign arb_io.VC0_out   = vc0_out_q;
  assign arb_io.VC1_out   = vc1_out_q;
  assign arb_io.VC0_count = vc0_cnt_q;
  assign arb_io.VC1_count = vc1_cnt_q;
  assign arb_io.idle      = (state_q == IDLE) & ~hold_v_q & arb_io.Main_empty;
endmodule

// File: tb/tb_arbitro_clasificacion.sv
// tb_arbitro_clasificacion: random and directed stimulus against a word-level model of the classifier
module tb_arbitro_clasificacion;
  logic clk = 1'b0;
  logic reset_L = 1'b0;
  always #5 clk = ~clk;
  arbitro_clasificacion_if #(.DATA_WIDTH(6), .CNT_W(5)) arb_if ();
  arbitro_clasificacion #(.DATA_WIDTH(6), .CLASS_BIT(5), .CNT_W(5)) dut (
    .clk(clk), .reset_L(reset_L), .arb_io(arb_if)
  );
  int checks = 0;
  int errors = 0;
  logic [5:0] q[$];
  logic p0 = 1'b0, p1 = 1'b0;
  logic cur_v = 1'b0, parked = 1'b0, nxt_v = 1'b0;
  logic [5:0] cur_w = '0, nxt = '0;
  logic e_push0 = 1'b0, e_push1 = 1'b0;
  logic [5:0] e_out0 = '0, e_out1 = '0;
  logic [4:0] e_cnt0 = '0, e_cnt1 = '0;
  logic paused, e_pop, e_idle;
  // Model view: at most one word sits at the classifier, either just popped or parked.
  task automatic tick();
    @(negedge clk);
    checks++; if (arb_if.VC0_push !== e_push0) begin errors++; $display("FAIL vc0_push t=%0t got %b exp %b", $time, arb_if.VC0_push, e_push0); end
    checks++; if (arb_if.VC1_push !== e_push1) begin errors++; $display("FAIL vc1_push t=%0t got %b exp %b", $time, arb_if.VC1_push, e_push1); end
    checks++; if (arb_if.VC0_out !== e_out0) begin errors++; $display("FAIL vc0_out t=%0t got %h exp %h", $time, arb_if.VC0_out, e_out0); end
    checks++; if (arb_if.VC1_out !== e_out1) begin errors++; $display("FAIL vc1_out t=%0t got %h exp %h", $time, arb_if.VC1_out, e_out1); end
    checks++; if (arb_if.VC0_count !== e_cnt0) begin errors++; $display("FAIL vc0_count t=%0t got %0d exp %0d", $time, arb_if.VC0_count, e_cnt0); end
    checks++; if (arb_if.VC1_count !== e_cnt1) begin errors++; $display("FAIL vc1_count t=%0t got %0d exp %0d", $time, arb_if.VC1_count, e_cnt1); end
    if (nxt_v) begin
      cur_v = 1'b1; cur_w = nxt; parked = 1'b0; arb_if.Main_in = nxt;
    end else begin
      arb_if.Main_in = 6'($urandom);
    end
    nxt_v = 1'b0;
    arb_if.Main_empty = (q.size() == 0);
    arb_if.VC0_pause = p0;
    arb_if.VC1_pause = p1;
    #1;
    paused = cur_v && (cur_w[5] ? p1 : p0);
    e_pop  = (q.size() != 0) && !(cur_v && (parked || paused));
    e_idle = !cur_v && (q.size() == 0);
    checks++; if (arb_if.Main_pop !== e_pop) begin errors++; $display("FAIL main_pop t=%0t got %b exp %b", $time, arb_if.Main_pop, e_pop); end
    checks++; if (arb_if.idle !== e_idle) begin errors++; $display("FAIL idle t=%0t got %b exp %b", $time, arb_if.idle, e_idle); end
    e_push0 = 1'b0;
    e_push1 = 1'b0;
    if (cur_v && !paused) begin
      if (cur_w[5]) begin e_push1 = 1'b1; e_out1 = cur_w; e_cnt1 = e_cnt1 + 1'b1; end
      else begin e_push0 = 1'b1; e_out0 = cur_w; e_cnt0 = e_cnt0 + 1'b1; end
      cur_v = 1'b0;
    end else if (cur_v) begin
      parked = 1'b1;
    end
    if (e_pop) begin
      nxt = q.pop_front(); nxt_v = 1'b1;
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset_L = 1'b0;
    arb_if.Main_empty = 1'b1;
    q.delete();
    cur_v = 1'b0; parked = 1'b0; nxt_v = 1'b0;
    e_push0 = 1'b0; e_push1 = 1'b0; e_out0 = '0; e_out1 = '0; e_cnt0 = '0; e_cnt1 = '0;
    #1;
    checks++; if ({arb_if.VC0_push, arb_if.VC1_push} !== 2'b00) begin errors++; $display("FAIL rst_push got %b%b exp 00", arb_if.VC0_push, arb_if.VC1_push); end
    checks++; if ({arb_if.VC0_out, arb_if.VC1_out} !== 12'h000) begin errors++; $display("FAIL rst_out got %h %h exp 0", arb_if.VC0_out, arb_if.VC1_out); end
    checks++; if ({arb_if.VC0_count, arb_if.VC1_count} !== 10'h000) begin errors++; $display("FAIL rst_count got %0d %0d exp 0", arb_if.VC0_count, arb_if.VC1_count); end
    repeat (2) @(negedge clk);
    reset_L = 1'b1;
  endtask
  task automatic test_reset();
    p0 = 1'b0; p1 = 1'b0;
    do_reset();
    repeat (3) tick();
    checks++; if (arb_if.Main_pop !== 1'b0) begin errors++; $display("FAIL reset_pop got %b exp 0", arb_if.Main_pop); end
    checks++; if (arb_if.idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b exp 1", arb_if.idle); end
  endtask
  task automatic test_stream();
    q.push_back(6'h05); q.push_back(6'h25); q.push_back(6'h0A); q.push_back(6'h3F);
    repeat (8) tick();
    checks++; if (arb_if.VC0_count !== 5'd2) begin errors++; $display("FAIL stream_cnt0 got %0d exp 2", arb_if.VC0_count); end
    checks++; if (arb_if.VC1_count !== 5'd2) begin errors++; $display("FAIL stream_cnt1 got %0d exp 2", arb_if.VC1_count); end
    checks++; if (arb_if.VC0_out !== 6'h0A) begin errors++; $display("FAIL stream_out0 got %h exp 0a", arb_if.VC0_out); end
    checks++; if (arb_if.VC1_out !== 6'h3F) begin errors++; $display("FAIL stream_out1 got %h exp 3f", arb_if.VC1_out); end
  endtask
  task automatic test_hold();
    q.push_back(6'h21); q.push_back(6'h03);
    p1 = 1'b1;
    repeat (7) tick();
    checks++; if (arb_if.Main_pop !== 1'b0) begin errors++; $display("FAIL hold_pop got %b exp 0", arb_if.Main_pop); end
    checks++; if (arb_if.VC1_push !== 1'b0) begin errors++; $display("FAIL hold_push got %b exp 0", arb_if.VC1_push); end
    p1 = 1'b0;
    repeat (6) tick();
    checks++; if (arb_if.VC1_out !== 6'h21) begin errors++; $display("FAIL hold_out1 got %h exp 21", arb_if.VC1_out); end
    checks++; if (arb_if.VC0_out !== 6'h03) begin errors++; $display("FAIL hold_out0 got %h exp 03", arb_if.VC0_out); end
  endtask
  task automatic test_vc0_pause();
    logic [4:0] start;
    start = e_cnt1;
    q.push_back(6'h30); q.push_back(6'h31);
    p0 = 1'b1;
    repeat (5) tick();
    checks++; if (arb_if.VC1_count !== 5'(start + 5'd2)) begin errors++; $display("FAIL vc0p_cnt1 got %0d exp %0d", arb_if.VC1_count, start + 5'd2); end
    p0 = 1'b0;
  endtask
  task automatic test_reset_mid();
    q.push_back(6'h12);
    tick();
    do_reset();
    repeat (4) tick();
    checks++; if (arb_if.VC0_count !== 5'd0) begin errors++; $display("FAIL rmid_cnt0 got %0d exp 0", arb_if.VC0_count); end
    checks++; if (arb_if.VC0_out !== 6'h00) begin errors++; $display("FAIL rmid_out0 got %h exp 00", arb_if.VC0_out); end
  endtask
  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 33; i++) q.push_back({1'b0, 5'($urandom)});
    repeat (40) tick();
    checks++; if (arb_if.VC0_count !== 5'd1) begin errors++; $display("FAIL wrap_cnt0 got %0d exp 1", arb_if.VC0_count); end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      p0 = ($urandom_range(3) == 0);
      p1 = ($urandom_range(3) == 0);
      if (q.size() < 4 && $urandom_range(1) == 1) q.push_back(6'($urandom));
      tick();
    end
    p0 = 1'b0; p1 = 1'b0;
    repeat (20) tick();
    checks++; if (arb_if.idle !== 1'b1) begin errors++; $display("FAIL random_idle got %b exp 1", arb_if.idle); end
  endtask
  initial begin
    arb_if.Main_in = '0;
    arb_if.Main_empty = 1'b1;
    arb_if.VC0_pause = 1'b0;
    arb_if.VC1_pause = 1'b0;
    test_reset();
    test_stream();
    test_hold();
    test_vc0_pause();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/arbitro_clasificacion.md
Name: arbitro_clasificacion

Overview:
Ingress-side classifier that drains the main input FIFO and distributes each 6-bit word into virtual-channel FIFO VC0 or VC1. It sits upstream of the VC FIFOs, the mirror of the VC-to-destination router at their read side. It owns the Main FIFO pop, and the VC0/VC1 pushes. It honours per-VC pause (almost-full) through a one-entry hold register, so no word is lost or duplicated.

Parameters:
DATA_WIDTH, 6, word width of Main_in, VC0_out and VC1_out.
CLASS_BIT, 5, bit index selecting the VC: 0 selects VC0, 1 selects VC1.
CNT_W, 5, width of the per-VC push counters.

Ports:
clk  input  1  single clock; all state changes on the rising edge.
reset_L  input  1  asynchronous, active-low reset.
Main_in  input  DATA_WIDTH  Main FIFO read data; valid the cycle after Main_pop.
Main_empty  input  1  Main FIFO empty.
VC0_pause  input  1  VC0 FIFO almost-full; no push to VC0 while high.
VC1_pause  input  1  VC1 FIFO almost-full; no push to VC1 while high.
Main_pop  output  1  pop request to the Main FIFO (combinational).
VC0_push  output  1  registered one-cycle push strobe to VC0.
VC1_push  output  1  registered one-cycle push strobe to VC1.
VC0_out  output  DATA_WIDTH  registered data to VC0.
VC1_out  output  DATA_WIDTH  registered data to VC1.
VC0_count  output  CNT_W  words pushed to VC0, wraps modulo 2^CNT_W.
VC1_count  output  CNT_W  words pushed to VC1, wraps modulo 2^CNT_W.
idle  output  1  high when there is no pending word, the hold register is empty, and Main_empty is high.

Behaviour:
- Reset (reset_L low, asynchronous):
  - all registered outputs go to 0;
  - the pending flag, the hold register and its valid flag clear;
  - the state goes to IDLE.
  - A reset mid-transfer discards the in-flight word and produces no push after release.
- States:
  - IDLE: no word in flight.
  - FLOW: a pop was issued last cycle, so Main_in is valid this cycle.
  - HOLD: a word is parked because its target VC is paused.
- Target VC: tgt = word[CLASS_BIT]. The pause of the non-target VC has no effect on the word.
- Main_pop = ~Main_empty & (state != HOLD) & ~(state == FLOW & pause[tgt of Main_in]).
- IDLE transitions:
  - Main_pop=1 → FLOW.
  - Otherwise stay in IDLE.
- FLOW, target not paused:
  - on the edge, VCtgt_out <= Main_in, VCtgt_push <= 1, VCtgt_count += 1;
  - next state is FLOW if Main_pop=1 this cycle, otherwise IDLE.
- FLOW, target paused:
  - hold <= Main_in; state → HOLD; no push.
- HOLD:
  - each cycle, check pause[tgt of hold].
  - Low: push the hold word exactly as in FLOW, clear the hold, state → IDLE. Popping resumes the cycle after the drain.
  - High: stay in HOLD with no pop and no push.
- Latency and throughput:
  - Main_pop at cycle t gives a push visible at cycle t+2 when not paused.
  - Back-to-back pops sustain 1 word/cycle.
- Push strobes last exactly one cycle per word. VC0_push and VC1_push are never high together.
- Pause sampling: a pause that rises in the same cycle the word is classified parks the word; the push is not issued.
- Counter wrap: 2^CNT_W-1 + 1 → 0, with no flag.
- VCx_out holds its last pushed value while VCx_push is low.

Test Plan:
1. Reset then release with Main_empty=1 → all outputs 0, Main_pop=0, idle=1.
2. Main FIFO holds 0x05, 0x25, 0x0A, 0x3F; no pause → pops on cycles 0–3.
   - VC0_push on cycles 2 and 4 with data 0x05 and 0x0A.
   - VC1_push on cycles 3 and 5 with data 0x25 and 0x3F.
   - Final counts: VC0_count=2, VC1_count=2.
3. VC1_pause=1 during classification of 0x21 → HOLD, Main_pop=0, no push for 5 cycles.
   - Drop VC1_pause → exactly one VC1_push with data 0x21.
   - Popping restarts the following cycle.
4. VC0_pause=1 while streaming VC1-only words 0x30, 0x31 → both pushed to VC1 at full rate, VC0_push stays 0.
5. Assert reset_L=0 in the cycle after a pop of 0x12 → no push ever appears for 0x12, and counters are 0.
6. Push 33 words to VC0 with CNT_W=5 → VC0_count reads 1 after wrap.
